// File: rtl/invaders_pkg.sv
// invaders_pkg: shared types and constants for the alien formation.
//   formation_state_t : march FSM states
//   SpriteW / SpriteH : alien sprite dimensions in pixels
//   Def*              : default playfield geometry used as parameter defaults
package invaders_pkg;

  typedef enum logic [1:0] {
    StMarch,
    StDescend,
    StCleared,
    StLanded
  } formation_state_t;

  localparam int unsigned SpriteW = 16;
  localparam int unsigned SpriteH = 16;

  localparam int unsigned DefFieldMinX = 0;
  localparam int unsigned DefFieldMaxX = 639;
  localparam int unsigned DefFieldMaxY = 447;
  localparam int unsigned DefOriginX   = 16;
  localparam int unsigned DefOriginY   = 16;

endpackage

// File: rtl/alien_sprite_rom.sv
// alien_sprite_rom: 16x16 alien bitmap with a registered single-bit read.
//   clk   : system clock
//   rst   : asynchronous active-high reset, clears pixel
//   en    : scan position is inside a live alien's sprite cell
//   row   : sprite row 0..15 (0 = top)
//   col   : sprite column 0..15 (0 = left)
//   pixel : registered lit bit, one cycle after row/col/en
module alien_sprite_rom (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       pixel
);

  logic [15:0] row_bits;

  // Bit 15 of each word is the leftmost pixel.
  always_comb begin
    row_bits = 16'h0000;
    unique case (row)
      4'd0:  row_bits = 16'b0000011001100000;
      4'd1:  row_bits = 16'b0000011001100000;
      4'd2:  row_bits = 16'b0001111111111000;
      4'd3:  row_bits = 16'b0011111111111100;
      4'd4:  row_bits = 16'b0111001111001110;
      4'd5:  row_bits = 16'b0111001111001110;
      4'd6:  row_bits = 16'b1111111111111111;
      4'd7:  row_bits = 16'b1111111111111111;
      4'd8:  row_bits = 16'b1111111111111111;
      4'd9:  row_bits = 16'b1101111111111011;
      4'd10: row_bits = 16'b1101100000011011;
      4'd11: row_bits = 16'b1101100000011011;
      4'd12: row_bits = 16'b0001110000111000;
      4'd13: row_bits = 16'b0011000000001100;
      4'd14: row_bits = 16'b0110000000000110;
      4'd15: row_bits = 16'b1100000000000011;
      default: row_bits = 16'h0000;
    endcase
  end

  // ~col == 15 - col for a 4-bit column, mapping col 0 to bit 15.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel <= 1'b0;
    end else begin
      pixel <= en & row_bits[~col];
    end
  end

endmodule

// File: rtl/alien_formation.sv
// alien_formation: marching grid of aliens with shared stepping, edge reversal,
// descent, kill tracking and a registered scan-out pixel.
//   clk, rst                 : clock, asynchronous active-high reset
//   movement_frequency       : base step period in clk cycles (step every period+1)
//   restart                  : synchronous re-arm to the reset state
//   hit_valid/hit_col/hit_row: kill request for alien (hit_row, hit_col)
//   scan_x, scan_y           : current video pixel
//   graphics                 : alien pixel at scan position, one cycle latency
//   alive_mask, alive_count  : per-alien alive bits (r*COLS+c) and their count
//   formation_x, formation_y : formation top-left
//   cleared, landed          : all aliens dead / formation reached the landing line
// Build option: define ALIEN_SPEEDUP_EN to shorten the period by SPEEDUP_STEP per kill.
module alien_formation
  import invaders_pkg::*;
#(
  parameter int unsigned COLS         = 8,
  parameter int unsigned ROWS         = 4,
  parameter int unsigned SPACING_X    = 32,
  parameter int unsigned SPACING_Y    = 32,
  parameter int unsigned ORIGIN_X     = DefOriginX,
  parameter int unsigned ORIGIN_Y     = DefOriginY,
  parameter int unsigned FIELD_MIN_X  = DefFieldMinX,
  parameter int unsigned FIELD_MAX_X  = DefFieldMaxX,
  parameter int unsigned FIELD_MAX_Y  = DefFieldMaxY,
  parameter int unsigned STEP_X       = 2,
  parameter int unsigned STEP_Y       = 8,
  parameter int unsigned SPEEDUP_STEP = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          movement_frequency,
  input  logic                 restart,
  input  logic                 hit_valid,
  input  logic [3:0]           hit_col,
  input  logic [2:0]           hit_row,
  input  logic [15:0]          scan_x,
  input  logic [15:0]          scan_y,
  output logic                 graphics,
  output logic [ROWS*COLS-1:0] alive_mask,
  output logic [7:0]           alive_count,
  output logic [15:0]          formation_x,
  output logic [15:0]          formation_y,
  output logic                 cleared,
  output logic                 landed
);

  localparam int unsigned N      = ROWS * COLS;
  localparam int unsigned SxBits = $clog2(SPACING_X);
  localparam int unsigned SyBits = $clog2(SPACING_Y);

  formation_state_t state_q;
  logic [N-1:0]     mask_q;
  logic [7:0]       count_q;
  logic [15:0]      fx_q, fy_q, cnt_q;
  logic             dir_left_q;

  // Occupancy extents of the live grid.
  logic [COLS-1:0] col_alive;
  logic [ROWS-1:0] row_alive;
  int unsigned     left_col, right_col, low_row;

  always_comb begin
    col_alive = '0;
    row_alive = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (mask_q[r*COLS+c]) begin
          col_alive[c] = 1'b1;
          row_alive[r] = 1'b1;
        end
      end
    end
    left_col  = 0;
    right_col = 0;
    low_row   = 0;
    for (int unsigned c = COLS; c > 0; c--) begin
      if (col_alive[c-1]) left_col = c - 1;
    end
    for (int unsigned c = 0; c < COLS; c++) begin
      if (col_alive[c]) right_col = c;
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (row_alive[r]) low_row = r;
    end
  end

  // Edges in 16-bit so a formation that walked past x=0 wraps like formation_x does.
  logic [15:0] left_edge, right_edge, fy_desc, bottom_edge;
  assign left_edge   = fx_q + 16'(left_col * SPACING_X);
  assign right_edge  = fx_q + 16'(right_col * SPACING_X + (SpriteW - 1));
  assign fy_desc     = fy_q + 16'(STEP_Y);
  assign bottom_edge = fy_desc + 16'(low_row * SPACING_Y + (SpriteH - 1));

  logic hit_right, hit_left;
  assign hit_right = (32'(right_edge) + STEP_X) > FIELD_MAX_X;
  assign hit_left  = 32'(left_edge) < (FIELD_MIN_X + STEP_X);

  // Step period.
  logic [15:0] period;
`ifdef ALIEN_SPEEDUP_EN
  int unsigned killed, slow_sub;
  always_comb begin
    killed   = N - 32'(count_q);
    slow_sub = killed * SPEEDUP_STEP;
    if (32'(movement_frequency) > slow_sub) begin
      period = movement_frequency - 16'(slow_sub);
    end else begin
      period = 16'd1;
    end
  end
`else
  assign period = movement_frequency;
`endif

  logic step;
  assign step = (cnt_q >= period);

  // Hit decode against the current (pre-hit) mask.
  logic [N-1:0] hit_onehot;
  logic         hit_ok;
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      hit_onehot[i] = (i == 32'(hit_row) * COLS + 32'(hit_col));
    end
    hit_ok = hit_valid && (32'(hit_col) < COLS) && (32'(hit_row) < ROWS) &&
             |(mask_q & hit_onehot);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StMarch;
      mask_q     <= '1;
      count_q    <= 8'(N);
      fx_q       <= 16'(ORIGIN_X);
      fy_q       <= 16'(ORIGIN_Y);
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
    end else if (restart) begin
      state_q    <= StMarch;
      mask_q     <= '1;
      count_q    <= 8'(N);
      fx_q       <= 16'(ORIGIN_X);
      fy_q       <= 16'(ORIGIN_Y);
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
    end else begin
      unique case (state_q)
        StMarch, StDescend: begin
          if (count_q == 8'd0) begin
            state_q <= StCleared;
            cnt_q   <= '0;
          end else begin
            if (hit_ok) begin
              mask_q  <= mask_q & ~hit_onehot;
              count_q <= count_q - 8'd1;
            end
            if (step) begin
              cnt_q <= '0;
              if (state_q == StMarch) begin
                if (dir_left_q) begin
                  if (hit_left) state_q <= StDescend;
                  else          fx_q    <= fx_q - 16'(STEP_X);
                end else begin
                  if (hit_right) state_q <= StDescend;
                  else           fx_q    <= fx_q + 16'(STEP_X);
                end
              end else begin
                fy_q       <= fy_desc;
                dir_left_q <= ~dir_left_q;
                state_q    <= (32'(bottom_edge) >= FIELD_MAX_Y) ? StLanded : StMarch;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Scan-out: locate the cell under the scan position; out-of-formation wraps large.
  logic [15:0]  rel_x, rel_y;
  logic [N-1:0] pix_onehot;
  logic         pix_en;
  always_comb begin
    rel_x = scan_x - fx_q;
    rel_y = scan_y - fy_q;
    for (int unsigned i = 0; i < N; i++) begin
      pix_onehot[i] = (i == 32'(rel_y[15:SyBits]) * COLS + 32'(rel_x[15:SxBits]));
    end
    pix_en = (32'(rel_x[15:SxBits]) < COLS) && (32'(rel_y[15:SyBits]) < ROWS) &&
             (32'(rel_x[SxBits-1:0]) < SpriteW) && (32'(rel_y[SyBits-1:0]) < SpriteH) &&
             |(mask_q & pix_onehot);
  end

  alien_sprite_rom u_sprite_rom (
    .clk   (clk),
    .rst   (rst),
    .en    (pix_en),
    .row   (rel_y[3:0]),
    .col   (rel_x[3:0]),
    .pixel (graphics)
  );

  assign alive_mask  = mask_q;
  assign alive_count = count_q;
  assign formation_x = fx_q;
  assign formation_y = fy_q;
  assign cleared     = (state_q == StCleared);
  assign landed      = (state_q == StLanded);

endmodule

// File: tb/tb_alien_formation.sv
module tb_alien_formation;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] movement_frequency;
  logic        restart;
  logic        hit_valid;
  logic [3:0]  hit_col;
  logic [2:0]  hit_row;
  logic [15:0] scan_x, scan_y;
  logic        graphics;
  logic [31:0] alive_mask;
  logic [7:0]  alive_count;
  logic [15:0] formation_x, formation_y;
  logic        cleared, landed;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  alien_formation dut (
    .clk                (clk),
    .rst                (rst),
    .movement_frequency (movement_frequency),
    .restart            (restart),
    .hit_valid          (hit_valid),
    .hit_col            (hit_col),
    .hit_row            (hit_row),
    .scan_x             (scan_x),
    .scan_y             (scan_y),
    .graphics           (graphics),
    .alive_mask         (alive_mask),
    .alive_count        (alive_count),
    .formation_x        (formation_x),
    .formation_y        (formation_y),
    .cleared            (cleared),
    .landed             (landed)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_restart(input logic [15:0] f);
    movement_frequency = f;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask

  task automatic kill(input int r, input int c);
    hit_valid = 1'b1;
    hit_row   = 3'(r);
    hit_col   = 4'(c);
    tick(1);
    hit_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; restart = 1'b0; hit_valid = 1'b0; hit_col = '0; hit_row = '0;
    scan_x = 16'd0; scan_y = 16'd0; movement_frequency = 16'd3;
    #12 rst = 1'b0;
    total++; if (alive_mask !== 32'hFFFF_FFFF) $display("FAIL reset_mask got %h want ffffffff", alive_mask); else pass_cnt++;
    total++; if (alive_count !== 8'd32) $display("FAIL reset_count got %0d want 32", alive_count); else pass_cnt++;
    total++; if (formation_x !== 16'd16 || formation_y !== 16'd16)
      $display("FAIL reset_pos got %0d,%0d want 16,16", formation_x, formation_y); else pass_cnt++;
    total++; if ({graphics, cleared, landed} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {graphics, cleared, landed}); else pass_cnt++;
  endtask

  task automatic test_period;
    tick(3);
    total++; if (formation_x !== 16'd16) $display("FAIL period_before got %0d want 16", formation_x); else pass_cnt++;
    tick(1);
    total++; if (formation_x !== 16'd18) $display("FAIL period_first got %0d want 18", formation_x); else pass_cnt++;
    tick(4);
    total++; if (formation_x !== 16'd20) $display("FAIL period_second got %0d want 20", formation_x); else pass_cnt++;
  endtask

  task automatic test_march_edge;
    do_restart(16'd0);
    tick(192);
    total++; if (formation_x !== 16'd400) $display("FAIL edge_reach got %0d want 400", formation_x); else pass_cnt++;
    tick(1);
    total++; if (formation_x !== 16'd400 || formation_y !== 16'd16)
      $display("FAIL edge_hold got %0d,%0d want 400,16", formation_x, formation_y); else pass_cnt++;
    tick(1);
    total++; if (formation_x !== 16'd400 || formation_y !== 16'd24)
      $display("FAIL edge_descend got %0d,%0d want 400,24", formation_x, formation_y); else pass_cnt++;
    tick(1);
    total++; if (formation_x !== 16'd398) $display("FAIL edge_reverse got %0d want 398", formation_x); else pass_cnt++;
  endtask

  task automatic test_col7_edge;
    do_restart(16'd1000);
    for (int r = 0; r < 4; r++) kill(r, 7);
    total++; if (alive_mask !== 32'h7F7F_7F7F) $display("FAIL col7_mask got %h want 7f7f7f7f", alive_mask); else pass_cnt++;
    total++; if (alive_count !== 8'd28) $display("FAIL col7_count got %0d want 28", alive_count); else pass_cnt++;
    movement_frequency = 16'd0;
    tick(208);
    total++; if (formation_x !== 16'd432) $display("FAIL col7_reach got %0d want 432", formation_x); else pass_cnt++;
    tick(1);
    total++; if (formation_x !== 16'd432 || formation_y !== 16'd16)
      $display("FAIL col7_hold got %0d,%0d want 432,16", formation_x, formation_y); else pass_cnt++;
    tick(1);
    total++; if (formation_y !== 16'd24) $display("FAIL col7_descend got %0d want 24", formation_y); else pass_cnt++;
    tick(1);
    total++; if (formation_x !== 16'd430) $display("FAIL col7_reverse got %0d want 430", formation_x); else pass_cnt++;
  endtask

  task automatic test_double_hit;
    do_restart(16'd1000);
    kill(2, 3);
    total++; if (alive_count !== 8'd31) $display("FAIL hit1_count got %0d want 31", alive_count); else pass_cnt++;
    total++; if (alive_mask !== 32'hFFF7_FFFF) $display("FAIL hit1_mask got %h want fff7ffff", alive_mask); else pass_cnt++;
    kill(2, 3);
    total++; if (alive_count !== 8'd31) $display("FAIL hit2_count got %0d want 31", alive_count); else pass_cnt++;
    kill(0, 8);
    kill(4, 0);
    total++; if (alive_count !== 8'd31 || alive_mask !== 32'hFFF7_FFFF)
      $display("FAIL hit_range got %0d/%h want 31/fff7ffff", alive_count, alive_mask); else pass_cnt++;
  endtask

  task automatic test_graphics;
    do_restart(16'd1000);
    scan_x = 16'd10; scan_y = 16'd23; tick(1);
    total++; if (graphics !== 1'b0) $display("FAIL gfx_left got %b want 0", graphics); else pass_cnt++;
    scan_x = 16'd16; scan_y = 16'd23; #1;
    total++; if (graphics !== 1'b0) $display("FAIL gfx_latency got %b want 0", graphics); else pass_cnt++;
    tick(1);
    total++; if (graphics !== 1'b1) $display("FAIL gfx_lit got %b want 1", graphics); else pass_cnt++;
    scan_x = 16'd16; scan_y = 16'd16; tick(1);
    total++; if (graphics !== 1'b0) $display("FAIL gfx_corner got %b want 0", graphics); else pass_cnt++;
    scan_x = 16'd32; scan_y = 16'd23; tick(1);
    total++; if (graphics !== 1'b0) $display("FAIL gfx_gap got %b want 0", graphics); else pass_cnt++;
    scan_x = 16'd16; scan_y = 16'd119; tick(1);
    total++; if (graphics !== 1'b1) $display("FAIL gfx_row3 got %b want 1", graphics); else pass_cnt++;
    scan_x = 16'd16; scan_y = 16'd151; tick(1);
    total++; if (graphics !== 1'b0) $display("FAIL gfx_row4 got %b want 0", graphics); else pass_cnt++;
    scan_x = 16'd272; scan_y = 16'd23; tick(1);
    total++; if (graphics !== 1'b0) $display("FAIL gfx_col8 got %b want 0", graphics); else pass_cnt++;
    kill(0, 1);
    scan_x = 16'd48; scan_y = 16'd23; tick(1);
    total++; if (graphics !== 1'b0) $display("FAIL gfx_dead got %b want 0", graphics); else pass_cnt++;
    scan_x = 16'd80; scan_y = 16'd55; tick(1);
    total++; if (graphics !== 1'b1) $display("FAIL gfx_r1c2 got %b want 1", graphics); else pass_cnt++;
  endtask

  task automatic test_clear;
    do_restart(16'd1000);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) kill(r, c);
    total++; if (alive_count !== 8'd0 || alive_mask !== 32'h0)
      $display("FAIL clear_count got %0d/%h want 0/0", alive_count, alive_mask); else pass_cnt++;
    total++; if (cleared !== 1'b0) $display("FAIL clear_early got %b want 0", cleared); else pass_cnt++;
    tick(1);
    total++; if (cleared !== 1'b1) $display("FAIL clear_flag got %b want 1", cleared); else pass_cnt++;
    movement_frequency = 16'd0;
    tick(5);
    total++; if (formation_x !== 16'd16 || formation_y !== 16'd16)
      $display("FAIL clear_frozen got %0d,%0d want 16,16", formation_x, formation_y); else pass_cnt++;
    restart = 1'b1; hit_valid = 1'b1; hit_row = 3'd0; hit_col = 4'd0;
    tick(1);
    restart = 1'b0; hit_valid = 1'b0;
    total++; if (alive_mask !== 32'hFFFF_FFFF || alive_count !== 8'd32)
      $display("FAIL restart_mask got %h/%0d want ffffffff/32", alive_mask, alive_count); else pass_cnt++;
    total++; if (cleared !== 1'b0 || formation_x !== 16'd16)
      $display("FAIL restart_state got %b/%0d want 0/16", cleared, formation_x); else pass_cnt++;
  endtask

  task automatic test_landed;
    int n;
    do_restart(16'd0);
    n = 0;
    while (landed !== 1'b1 && n < 20000) begin
      tick(1);
      n++;
    end
    total++; if (landed !== 1'b1) $display("FAIL land_timeout got %b want 1", landed); else pass_cnt++;
    total++; if (formation_y !== 16'd336 || formation_x !== 16'd0)
      $display("FAIL land_pos got %0d,%0d want 0,336", formation_x, formation_y); else pass_cnt++;
    kill(0, 0);
    tick(10);
    total++; if (formation_y !== 16'd336 || formation_x !== 16'd0 || alive_count !== 8'd32)
      $display("FAIL land_frozen got %0d,%0d,%0d want 0,336,32", formation_x, formation_y, alive_count);
    else pass_cnt++;
  endtask

`ifdef ALIEN_SPEEDUP_EN
  task automatic test_speedup;
    do_restart(16'd100);
    kill(0, 0);
    kill(0, 1);
    tick(1);
    total++; if (formation_x !== 16'd18) $display("FAIL speed_first got %0d want 18", formation_x); else pass_cnt++;
    tick(1);
    total++; if (formation_x !== 16'd18) $display("FAIL speed_hold got %0d want 18", formation_x); else pass_cnt++;
    tick(1);
    total++; if (formation_x !== 16'd20) $display("FAIL speed_second got %0d want 20", formation_x); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_period();
    test_march_edge();
    test_col7_edge();
    test_double_hit();
    test_graphics();
    test_clear();
    test_landed();
`ifdef ALIEN_SPEEDUP_EN
    test_speedup();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
